// File: rtl/srom_boot_loader.sv
// Copies WORD_COUNT words from a SPI serial ROM (fast-read 0x0B) into an
// external async SRAM at power-up or on reload, then serves reads from it.
module srom_boot_loader #(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 15,
  parameter int          WORD_COUNT = 2**ADDR_W,
  parameter logic [23:0] SROM_BASE  = 24'h000000,
  parameter int          DUMMY_BITS = 8
) (
  input  logic              clk_srom,
  input  logic              rst_n,
  input  logic              reload,
  output logic              ready,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              srom_cs_n,
  output logic              srom_sck,
  output logic              srom_di,
  input  logic              srom_do,
  output logic [ADDR_W-1:0] sram_address,
  inout  wire logic [DATA_W-1:0] sram_dio,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int HDR_W = 32 + DUMMY_BITS;
  localparam int MAX_B = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_B) + 1;
  // Command, address and dummy zeros form one MSB-first header shifted out back to back.
  localparam logic [HDR_W-1:0]  HEADER     = HDR_W'({8'h0B, SROM_BASE}) << DUMMY_BITS;
  localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(23);
  localparam logic [CNT_W-1:0]  DUMMY_LAST = CNT_W'(DUMMY_BITS - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, WRITE, DONE} state_t;

  state_t            state;
  logic              pending;
  logic              phase;
  logic [CNT_W-1:0]  cnt;
  logic [HDR_W-1:0]  hdr;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] waddr;

  always_ff @(posedge clk_srom or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b0;
      checksum  <= '0;
      srom_cs_n <= 1'b1;
      srom_sck  <= 1'b0;
      srom_di   <= 1'b0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      waddr     <= '0;
      pending   <= 1'b1;
      phase     <= 1'b0;
      cnt       <= '0;
      hdr       <= '0;
      word      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            pending   <= 1'b0;
            srom_cs_n <= 1'b0;
            waddr     <= '0;
            state     <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          srom_di <= HEADER[HDR_W-1];
          hdr     <= HEADER << 1;
          phase   <= 1'b0;
          cnt     <= '0;
          state   <= CMD;
        end
        CMD, ADDR, DUMMY: begin
          if (!phase) begin
            srom_sck <= 1'b1;
            phase    <= 1'b1;
          end else begin
            srom_sck <= 1'b0;
            phase    <= 1'b0;
            srom_di  <= hdr[HDR_W-1];
            hdr      <= hdr << 1;
            cnt      <= cnt + 1'b1;
            if (state == CMD && cnt == CMD_LAST) begin
              state <= ADDR;
              cnt   <= '0;
            end else if (state == ADDR && cnt == ADDR_LAST) begin
              state <= (DUMMY_BITS > 0) ? DUMMY : DATA;
              cnt   <= '0;
            end else if (state == DUMMY && cnt == DUMMY_LAST) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
        end
        DATA: begin
          if (!phase) begin
            srom_sck <= 1'b1;
            phase    <= 1'b1;
          end else begin
            srom_sck <= 1'b0;
            phase    <= 1'b0;
            word     <= {word[DATA_W-2:0], srom_do};
            cnt      <= cnt + 1'b1;
            if (cnt == DATA_LAST) begin
              sram_we_n <= 1'b0;
              cnt       <= '0;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          // The we_n level doubles as the sub-cycle marker for the two-cycle write.
          if (!sram_we_n) begin
            sram_we_n <= 1'b1;
          end else begin
            checksum <= checksum + word;
            waddr    <= waddr + 1'b1;
            state    <= (waddr == LAST_ADDR) ? DONE : DATA;
          end
        end
        DONE: begin
          srom_cs_n <= 1'b1;
          ready     <= 1'b1;
          sram_oe_n <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (reload && ready) begin
        ready     <= 1'b0;
        checksum  <= '0;
        pending   <= 1'b1;
        sram_oe_n <= 1'b1;
      end
    end
  end

  assign sram_ce_n    = 1'b0;
  assign sram_address = ready ? address : waddr;
  assign sram_dio     = ready ? {DATA_W{1'bz}} : word;
  assign data         = ready ? sram_dio : '0;

endmodule

// File: tb/tb_srom_boot_loader.sv
// Scoreboard bench for srom_boot_loader with SPI flash and async SRAM models.
module tb_srom_boot_loader;
  localparam int DW = 16, AW = 4, WC = 16, DB = 8, LOAD_EDGES = 627;

  logic          clk_srom = 1'b0;
  logic          rst_n = 1'b0;
  logic          reload = 1'b0;
  logic [AW-1:0] address = '0;
  logic          srom_do = 1'b0;
  logic          ready;
  logic [DW-1:0] checksum, data;
  logic          srom_cs_n, srom_sck, srom_di;
  logic [AW-1:0] sram_address;
  wire  [DW-1:0] sram_dio;
  logic          sram_ce_n, sram_oe_n, sram_we_n;

  logic [DW-1:0] mem [WC];
  int   vectors = 0, miscompares = 0;
  logic ffff_mode = 1'b0;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  int            nbits = 0, bad_sck = 0, bad_we = 0, we_lows = 0;
  logic [39:0]   hdr_cap = '0;
  logic          we_prev = 1'b1;

  always #5 clk_srom = ~clk_srom;

  srom_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .WORD_COUNT(WC),
                     .SROM_BASE(24'h010000), .DUMMY_BITS(DB)) dut (
    .clk_srom(clk_srom), .rst_n(rst_n), .reload(reload), .ready(ready),
    .checksum(checksum), .address(address), .data(data),
    .srom_cs_n(srom_cs_n), .srom_sck(srom_sck), .srom_di(srom_di), .srom_do(srom_do),
    .sram_address(sram_address), .sram_dio(sram_dio), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  assign sram_dio = !sram_oe_n ? mem[sram_address] : 'z;

  always @(posedge clk_srom)
    if (rst_n && !sram_we_n) mem[sram_address] <= sram_dio;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash model: captures the header on each sck rise and presents the next data bit.
  always @(posedge srom_sck or negedge srom_cs_n) begin
    int d;
    logic [15:0] w;
    if (srom_sck) begin
      if (nbits < 40) hdr_cap[39-nbits] = srom_di;
      else begin
        d = nbits - 40;
        w = ffff_mode ? 16'hFFFF : 16'hA000 + 16'(d / 16);
        srom_do = w[15 - (d % 16)];
      end
      nbits++;
    end else begin
      nbits = 0;
      hdr_cap = '0;
    end
  end

  always @(negedge clk_srom) begin
    wr_t e;
    if (rst_n) begin
      if (srom_cs_n && srom_sck) bad_sck++;
      if (!sram_we_n) begin
        we_lows++;
        if (!we_prev) bad_we++;
        if (wr_q.size() == 0) check("wr_extra", 1, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", sram_address, e.a);
          check("wr_data", sram_dio, e.d);
        end
      end
      we_prev = sram_we_n;
    end else begin
      we_prev = 1'b1;
    end
  end

  task automatic start_expect();
    wr_q.delete();
    for (int k = 0; k < WC; k++)
      wr_q.push_back({4'(k), ffff_mode ? 16'hFFFF : 16'hA000 + 16'(k)});
    we_lows = 0;
  endtask

  task automatic run_load(input int pulse_at, output int n);
    n = 0;
    while (1) begin
      @(negedge clk_srom);
      reload = (n + 1 == pulse_at);
      @(posedge clk_srom);
      #1;
      n++;
      if (ready || n >= 2000) break;
    end
    reload = 1'b0;
  endtask

  task automatic end_load(input string tag, input int n, input logic [15:0] exp_sum);
    check({tag, "_edges"}, n, LOAD_EDGES);
    check({tag, "_sum"}, checksum, exp_sum);
    check({tag, "_hdr"}, hdr_cap, 40'h0B_010000_00);
    check({tag, "_sck"}, nbits, 40 + WC * DW);
    check({tag, "_we"}, we_lows, WC);
    check({tag, "_wrq"}, wr_q.size(), 0);
  endtask

  task automatic pulse_reload();
    @(negedge clk_srom);
    reload = 1'b1;
    @(posedge clk_srom);
    #1;
    reload = 1'b0;
    check("rl_ready", ready, 0);
    check("rl_sum", checksum, 0);
  endtask

  task automatic read_words(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk_srom);
      address = 4'(k);
      rd_q.push_back(ffff_mode ? 16'hFFFF : 16'hA000 + 16'(k));
      #1;
      check("rd_data", data, rd_q.pop_front());
      check("rd_we", sram_we_n, 1);
      check("rd_oe", sram_oe_n, 0);
    end
  endtask

  initial begin
    int   n;
    logic found;
    repeat (3) @(posedge clk_srom);
    #1;
    check("rst_ready", ready, 0);
    check("rst_sum", checksum, 0);
    check("rst_cs", srom_cs_n, 1);
    check("rst_sck", srom_sck, 0);
    check("rst_di", srom_di, 0);
    check("rst_we", sram_we_n, 1);
    check("rst_oe", sram_oe_n, 1);
    check("rst_ce", sram_ce_n, 0);
    check("rst_data", data, 0);

    start_expect();
    @(posedge clk_srom);
    #2 rst_n = 1'b1;
    run_load(0, n);
    end_load("load1", n, 16'h0078);
    read_words(0, WC - 1);

    ffff_mode = 1'b1;
    start_expect();
    pulse_reload();
    check("ld_data", data, 0);
    run_load(0, n);
    end_load("ffff", n, 16'hFFF0);
    read_words(0, 1);
    read_words(WC - 1, WC - 1);

    ffff_mode = 1'b0;
    start_expect();
    pulse_reload();
    run_load(300, n);
    end_load("rl300", n, 16'h0078);

    ffff_mode = 1'b1;
    start_expect();
    pulse_reload();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_srom);
      if (!sram_we_n && sram_address == 4'd7) found = 1'b1;
    end
    check("w7_found", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs", srom_cs_n, 1);
    check("abort_we", sram_we_n, 1);
    check("abort_sck", srom_sck, 0);
    start_expect();
    @(posedge clk_srom);
    #2 rst_n = 1'b1;
    run_load(0, n);
    end_load("rst7", n, 16'hFFF0);
    read_words(6, 8);

    check("sck_while_cs_high", bad_sck, 0);
    check("we_multi_cycle", bad_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
